// File: rtl/image_rx_ctrl.sv
`default_nettype none
//============================================================================
// Module   : image_rx_ctrl
// Brief    : SPI image receive controller. It decodes command bytes, loads an
//            image into the buffer and handshakes the inference engine.
//            The load idle timeout is built only when IMAGE_RX_TIMEOUT_EN is
//            defined.
// Revision : 1.0
//============================================================================
module image_rx_ctrl #(
  parameter int IMG_BYTES      = 113,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] spi_rx_data,
  output logic       rx_enable,
  output logic       byte_taken,
  output logic       buf_we,
  output logic [6:0] buf_addr,
  output logic [7:0] buf_wdata,
  output logic       infer_start,
  input  logic       infer_done,
  output logic       image_ready,
  output logic       blank_image,
  output logic       busy,
  output logic       cmd_err,
  output logic       rx_err
);

  localparam logic [7:0] C_CMD_LOAD  = 8'hA5;
  localparam logic [7:0] C_CMD_INFER = 8'h5A;
  localparam logic [7:0] C_CMD_CLEAR = 8'hFF;
  localparam logic [6:0] C_LAST_IDX  = 7'(IMG_BYTES - 1);

  typedef enum logic [1:0] {
    S_CMD    = 2'd0,
    S_LOAD   = 2'd1,
    S_LOADED = 2'd2,
    S_INFER  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [1:0] hold_q, hold_d;
  logic       last_q, last_d;
  logic       blank_trk_q, blank_trk_d;
  logic       rx_enable_q, rx_enable_d;
  logic       byte_taken_q, byte_taken_d;
  logic       buf_we_q, buf_we_d;
  logic [6:0] buf_addr_q, buf_addr_d;
  logic [7:0] buf_wdata_q, buf_wdata_d;
  logic       infer_start_q, infer_start_d;
  logic       image_ready_q, image_ready_d;
  logic       blank_image_q, blank_image_d;
  logic       cmd_err_q, cmd_err_d;
  logic       w_accept;
  logic       w_tmo_hit;

  // The two-cycle holdoff keeps a still-asserted byte_valid from being consumed twice.
  assign w_accept = byte_valid && rx_enable_q && (hold_q == 2'd0);

`ifdef IMAGE_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rx_err_q;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + CW'(1);
    if ((state_q != S_LOAD) || last_q || w_accept) tmo_cnt_d = '0;
  end

  assign w_tmo_hit = (state_q == S_LOAD) && !last_q && !w_accept &&
                     (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      rx_err_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rx_err_q  <= w_tmo_hit;
    end
  end

  assign rx_err = rx_err_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit        = 1'b0;
  assign rx_err           = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = 1'b0;
    blank_trk_d   = blank_trk_q;
    hold_d        = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    byte_taken_d  = w_accept;
    buf_we_d      = 1'b0;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    infer_start_d = 1'b0;
    image_ready_d = image_ready_q;
    blank_image_d = blank_image_q;
    cmd_err_d     = 1'b0;

    if (w_accept) hold_d = 2'd2;

    case (state_q)
      S_CMD, S_LOADED: begin
        if (w_accept) begin
          case (spi_rx_data)
            C_CMD_LOAD: begin
              state_d       = S_LOAD;
              idx_d         = '0;
              image_ready_d = 1'b0;
              blank_image_d = 1'b0;
              blank_trk_d   = 1'b1;
            end
            C_CMD_INFER: begin
              if (state_q == S_LOADED) begin
                state_d       = S_INFER;
                infer_start_d = 1'b1;
              end else begin
                cmd_err_d = 1'b1;
              end
            end
            C_CMD_CLEAR: begin
              state_d       = S_CMD;
              image_ready_d = 1'b0;
              blank_image_d = 1'b0;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        // The final write is issued while still in LOAD; LOADED follows a cycle later.
        if (last_q) begin
          state_d       = S_LOADED;
          image_ready_d = 1'b1;
          blank_image_d = blank_trk_q;
        end else if (w_accept) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = idx_q;
          buf_wdata_d = spi_rx_data;
          blank_trk_d = blank_trk_q && (spi_rx_data == 8'h00);
          if (idx_q == C_LAST_IDX) last_d = 1'b1;
          else                     idx_d  = idx_q + 7'd1;
        end else if (w_tmo_hit) begin
          state_d       = S_CMD;
          image_ready_d = 1'b0;
        end
      end
      S_INFER: begin
        if (infer_done) state_d = S_LOADED;
      end
      default: state_d = S_CMD;
    endcase

    rx_enable_d = (state_d != S_INFER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_CMD;
      idx_q         <= '0;
      hold_q        <= '0;
      last_q        <= 1'b0;
      blank_trk_q   <= 1'b0;
      rx_enable_q   <= 1'b1;
      byte_taken_q  <= 1'b0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_wdata_q   <= '0;
      infer_start_q <= 1'b0;
      image_ready_q <= 1'b0;
      blank_image_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      last_q        <= last_d;
      blank_trk_q   <= blank_trk_d;
      rx_enable_q   <= rx_enable_d;
      byte_taken_q  <= byte_taken_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      infer_start_q <= infer_start_d;
      image_ready_q <= image_ready_d;
      blank_image_q <= blank_image_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign busy        = (state_q != S_CMD);
  assign rx_enable   = rx_enable_q;
  assign byte_taken  = byte_taken_q;
  assign buf_we      = buf_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_wdata   = buf_wdata_q;
  assign infer_start = infer_start_q;
  assign image_ready = image_ready_q;
  assign blank_image = blank_image_q;
  assign cmd_err     = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_image_rx_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_image_rx_ctrl
// Brief    : Self-checking bench for image_rx_ctrl with an image-level model.
// Revision : 1.0
//============================================================================
module tb_image_rx_ctrl;
  localparam int IMG = 113;
  localparam int TMO = 10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] spi_rx_data = 8'h00;
  logic       infer_done = 1'b0;
  logic       rx_enable, byte_taken, buf_we, infer_start;
  logic       image_ready, blank_image, busy, cmd_err, rx_err;
  logic [6:0] buf_addr;
  logic [7:0] buf_wdata;

  image_rx_ctrl #(.IMG_BYTES(IMG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .spi_rx_data(spi_rx_data),
    .rx_enable(rx_enable), .byte_taken(byte_taken), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .infer_start(infer_start),
    .infer_done(infer_done), .image_ready(image_ready), .blank_image(blank_image),
    .busy(busy), .cmd_err(cmd_err), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event counters (cycles high) and the captured buffer writes.
  int n_taken, n_we, n_we_bad, n_start, n_start_bad, n_cmd_err, n_rx_err;
  logic [6:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] img[IMG];

  always @(negedge clk) begin
    if (byte_taken) n_taken++;
    if (buf_we) begin
      n_we++;
      wa.push_back(buf_addr);
      wd.push_back(buf_wdata);
      if (!byte_taken || !busy || buf_addr > 7'(IMG - 1)) n_we_bad++;
    end
    if (infer_start) begin
      n_start++;
      if (!byte_taken) n_start_bad++;
    end
    if (cmd_err) n_cmd_err++;
    if (rx_err)  n_rx_err++;
  end

  task automatic mon_clear();
    n_taken = 0; n_we = 0; n_we_bad = 0; n_start = 0; n_start_bad = 0;
    n_cmd_err = 0; n_rx_err = 0;
    wa.delete();
    wd.delete();
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    byte_valid  = 1'b1;
    spi_rx_data = b;
    @(posedge clk); #1;
    byte_valid  = 1'b0;
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic load_image(input int gap_max);
    send_byte(8'hA5);
    for (int i = 0; i < IMG; i++) begin
      send_byte(img[i]);
      idle(int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    infer_done = 1'b1;
    @(posedge clk); #1;
    infer_done = 1'b0;
  endtask

  // Number of differences between the captured writes and the model image.
  function automatic int img_diffs();
    int d = 0;
    if (wa.size() != IMG) d += 1000;
    for (int i = 0; i < IMG && i < wa.size(); i++)
      if (wa[i] !== 7'(i) || wd[i] !== img[i]) d++;
    return d;
  endfunction

  function automatic bit img_blank();
    for (int i = 0; i < IMG; i++) if (img[i] != 8'h00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] rand_noncmd();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == 8'hA5 || b == 8'h5A || b == 8'hFF);
    return b;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (rx_enable !== 1'b1) begin errors++; $display("FAIL reset_rx_enable: got %b want 1", rx_enable); end
    checks++;
    if ({busy, image_ready, blank_image, byte_taken, buf_we, infer_start, cmd_err, rx_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000000",
               {busy, image_ready, blank_image, byte_taken, buf_we, infer_start, cmd_err, rx_err});
    end
    checks++;
    if ({buf_addr, buf_wdata} !== 15'h0) begin errors++; $display("FAIL reset_buf: addr %0d data %0h want 0 0", buf_addr, buf_wdata); end
  endtask

  task automatic test_load_sequential();
    for (int i = 0; i < IMG; i++) img[i] = 8'(i + 1);
    mon_clear();
    load_image(0);
    checks++;
    if (img_diffs() !== 0) begin errors++; $display("FAIL seq_writes: %0d diffs (%0d writes) want 0 diffs", img_diffs(), wa.size()); end
    checks++;
    if (n_we !== IMG || n_taken !== IMG + 1 || n_we_bad !== 0) begin
      errors++; $display("FAIL seq_counts: we %0d taken %0d bad %0d want %0d %0d 0", n_we, n_taken, n_we_bad, IMG, IMG + 1);
    end
    checks++;
    if ({image_ready, blank_image, busy} !== 3'b101) begin
      errors++; $display("FAIL seq_status: rdy/blank/busy %b want 101", {image_ready, blank_image, busy});
    end
  endtask

  task automatic test_blank_infer();
    for (int i = 0; i < IMG; i++) img[i] = 8'h00;
    mon_clear();
    load_image(1);
    checks++;
    if ({image_ready, blank_image} !== 2'b11 || img_diffs() !== 0) begin
      errors++; $display("FAIL blank_load: rdy/blank %b diffs %0d want 11 0", {image_ready, blank_image}, img_diffs());
    end
    mon_clear();
    send_byte(8'h5A);
    checks++;
    if (n_start !== 1 || n_start_bad !== 0 || rx_enable !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL infer_start: starts %0d bad %0d rx_en %b busy %b want 1 0 0 1", n_start, n_start_bad, rx_enable, busy);
    end
    send_byte(8'h33);
    checks++;
    if (n_taken !== 1 || n_cmd_err !== 0 || n_we !== 0) begin
      errors++; $display("FAIL infer_ignore: taken %0d cmd_err %0d we %0d want 1 0 0", n_taken, n_cmd_err, n_we);
    end
    idle(int'($urandom_range(0, 5)));
    pulse_done();
    checks++;
    if ({rx_enable, image_ready, blank_image, busy} !== 4'b1111 || n_start !== 1) begin
      errors++; $display("FAIL infer_done: en/rdy/blank/busy %b starts %0d want 1111 1", {rx_enable, image_ready, blank_image, busy}, n_start);
    end
  endtask

  task automatic test_holdoff();
    logic [7:0] b;
    b = 8'($urandom_range(1, 255));
    mon_clear();
    send_byte(8'hA5);
    @(posedge clk); #1;
    byte_valid  = 1'b1;
    spi_rx_data = b;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    idle(2);
    checks++;
    if (n_taken !== 2 || n_we !== 1) begin
      errors++; $display("FAIL holdoff: taken %0d we %0d want 2 1", n_taken, n_we);
    end
    img[0] = b;
    for (int i = 1; i < IMG; i++) begin
      img[i] = 8'($urandom_range(0, 255));
      send_byte(img[i]);
    end
    checks++;
    if (img_diffs() !== 0 || image_ready !== 1'b1 || blank_image !== img_blank()) begin
      errors++; $display("FAIL holdoff_image: diffs %0d rdy %b blank %b want 0 1 %b", img_diffs(), image_ready, blank_image, img_blank());
    end
  endtask

  task automatic test_cmd_errors();
    int k;
    do_reset();
    mon_clear();
    send_byte(8'h5A);
    send_byte(8'h33);
    pulse_done();
    idle(2);
    checks++;
    if (n_cmd_err !== 2 || n_start !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL cmd_in_cmd: cmd_err %0d starts %0d busy %b want 2 0 0", n_cmd_err, n_start, busy);
    end
    for (int i = 0; i < IMG; i++) img[i] = 8'($urandom_range(0, 255));
    load_image(2);
    send_byte(8'hFF);
    checks++;
    if ({image_ready, blank_image, busy} !== 3'b000) begin
      errors++; $display("FAIL clear_cmd: rdy/blank/busy %b want 000", {image_ready, blank_image, busy});
    end
    load_image(0);
    mon_clear();
    k = int'($urandom_range(1, 5));
    for (int i = 0; i < k; i++) send_byte(rand_noncmd());
    checks++;
    if (n_cmd_err !== k || image_ready !== 1'b1 || busy !== 1'b1 || n_we !== 0) begin
      errors++; $display("FAIL cmd_in_loaded: cmd_err %0d rdy %b busy %b we %0d want %0d 1 1 0", n_cmd_err, image_ready, busy, n_we, k);
    end
  endtask

  task automatic test_timeout();
    int seen;
    for (int i = 0; i < IMG; i++) img[i] = 8'($urandom_range(0, 255));
    mon_clear();
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(img[i]);
    seen = 0;
    for (int n = 1; n <= TMO + 50; n++) begin
      @(negedge clk);
      if (rx_err) begin seen = n; break; end
    end
    @(posedge clk); #1;
    idle(2);
`ifdef IMAGE_RX_TIMEOUT_EN
    checks++;
    if (seen < TMO - 10 || seen > TMO + 10) begin
      errors++; $display("FAIL timeout_time: rx_err after %0d idle cycles want about %0d", seen, TMO);
    end
    checks++;
    if (n_rx_err !== 1 || busy !== 1'b0 || image_ready !== 1'b0) begin
      errors++; $display("FAIL timeout_state: rx_err %0d busy %b rdy %b want 1 0 0", n_rx_err, busy, image_ready);
    end
`else
    checks++;
    if (seen !== 0 || n_rx_err !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL no_timeout: rx_err at %0d count %0d busy %b want 0 0 1", seen, n_rx_err, busy);
    end
    for (int i = 10; i < IMG; i++) send_byte(img[i]);
    checks++;
    if (img_diffs() !== 0 || image_ready !== 1'b1) begin
      errors++; $display("FAIL no_timeout_image: diffs %0d rdy %b want 0 1", img_diffs(), image_ready);
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    mon_clear();
    send_byte(8'hA5);
    for (int i = 0; i < 50; i++) send_byte(8'($urandom_range(0, 255)));
    @(posedge clk); #1;
    byte_valid  = 1'b1;
    spi_rx_data = 8'h77;
    rst_n       = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, buf_we, image_ready, infer_start, cmd_err, rx_err} !== 6'b0 || buf_addr !== 7'd0 || rx_enable !== 1'b1) begin
      errors++; $display("FAIL mid_reset: busy %b we %b rdy %b addr %0d rx_en %b want 0 0 0 0 1", busy, buf_we, image_ready, buf_addr, rx_enable);
    end
    byte_valid = 1'b0;
    rst_n      = 1'b1;
    idle(1);
    checks++;
    if (n_we !== 50) begin errors++; $display("FAIL mid_reset_writes: %0d writes want 50", n_we); end
    for (int i = 0; i < IMG; i++) img[i] = 8'($urandom_range(0, 255));
    mon_clear();
    load_image(1);
    checks++;
    if (img_diffs() !== 0 || image_ready !== 1'b1) begin
      errors++; $display("FAIL reload: diffs %0d rdy %b want 0 1", img_diffs(), image_ready);
    end
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < IMG; i++) img[i] = (it == 0 || it == 3) ? 8'($urandom_range(0, 255)) : 8'h00;
      if (it == 1) img[IMG - 1] = 8'($urandom_range(1, 255));
      if (it == 2) img[$urandom_range(0, IMG - 1)] = 8'($urandom_range(1, 255));
      mon_clear();
      load_image(3);
      checks++;
      if (img_diffs() !== 0 || n_we !== IMG || n_we_bad !== 0) begin
        errors++; $display("FAIL rand_writes[%0d]: diffs %0d we %0d bad %0d want 0 %0d 0", it, img_diffs(), n_we, n_we_bad, IMG);
      end
      checks++;
      if (image_ready !== 1'b1 || blank_image !== img_blank()) begin
        errors++; $display("FAIL rand_status[%0d]: rdy %b blank %b want 1 %b", it, image_ready, blank_image, img_blank());
      end
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'h5A);
        idle(int'($urandom_range(0, 4)));
        pulse_done();
        checks++;
        if (n_start !== 1 || rx_enable !== 1'b1 || busy !== 1'b1 || image_ready !== 1'b1) begin
          errors++; $display("FAIL rand_infer[%0d]: starts %0d rx_en %b busy %b rdy %b want 1 1 1 1", it, n_start, rx_enable, busy, image_ready);
        end
      end
    end
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_load_sequential();
    test_blank_infer();
    test_holdoff();
    test_cmd_errors();
    test_timeout();
    test_reset_mid_load();
    test_random_loads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/image_rx_ctrl.md
IMAGE_RX_CTRL -- requirements
Module: image_rx_ctrl

Interface
REQ-001 SHALL have parameter IMG_BYTES, default 113, number of bytes per image frame (30x30 bits, zero-padded).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000, maximum idle clk cycles between image bytes.
REQ-003 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: byte_valid  in  1  SPI byte available; spi_rx_data  in  8  SPI byte; rx_enable  out  1  permit SPI receive; byte_taken  out  1  single-cycle consume pulse.
REQ-005 SHALL have ports: buf_we  out  1  image buffer write strobe; buf_addr  out  7  byte index; buf_wdata  out  8  byte data.
REQ-006 SHALL have ports: infer_start  out  1  single-cycle inference start; infer_done  in  1  inference complete pulse; image_ready  out  1  full image held in buffer; blank_image  out  1  all image bytes zero; busy  out  1  state is not CMD; cmd_err  out  1  unknown-command pulse; rx_err  out  1  load-timeout pulse.

Function
REQ-007 SHALL implement states CMD, LOAD, LOADED, INFER.
REQ-008 SHALL accept a byte in any cycle with byte_valid=1, rx_enable=1 and holdoff=0; holdoff SHALL be 1 for the 2 cycles after an acceptance, so a lingering byte_valid is never consumed twice.
REQ-009 SHALL assert byte_taken for exactly 1 cycle, the cycle after acceptance.
REQ-010 SHALL keep rx_enable=1 in CMD, LOAD, LOADED and 0 in INFER.
REQ-011 In CMD/LOADED, accepted byte 0xA5 SHALL enter LOAD with byte index 0, clear image_ready, set blank tracking to 1.
REQ-012 In LOADED, accepted byte 0x5A SHALL pulse infer_start for 1 cycle (same cycle as byte_taken) and enter INFER; in CMD, 0x5A SHALL pulse cmd_err instead.
REQ-013 In CMD/LOADED, accepted byte 0xFF SHALL clear image_ready and blank_image and enter CMD; any other byte SHALL pulse cmd_err and leave state unchanged.
REQ-014 In LOAD, each accepted byte SHALL produce buf_we=1 for 1 cycle, coincident with byte_taken, with buf_addr=current index and buf_wdata=that byte; the index then SHALL increment.
REQ-015 When the write at index IMG_BYTES-1 occurs, SHALL enter LOADED the next cycle with image_ready=1 and blank_image=1 only if every written byte was 0x00.
REQ-016 In LOAD, a cycle counter SHALL reset on each acceptance; reaching TIMEOUT_CYCLES without acceptance SHALL pulse rx_err, enter CMD, leave image_ready=0.
REQ-017 In INFER, infer_done=1 SHALL return to LOADED next cycle (image_ready stays 1); byte_valid SHALL be ignored and not taken.
REQ-018 infer_done outside INFER SHALL be ignored.
REQ-019 Acceptance and timeout in the same cycle: acceptance SHALL win.
REQ-020 buf_addr SHALL never exceed IMG_BYTES-1; buf_we SHALL be 0 outside LOAD.
REQ-021 busy SHALL equal (state != CMD), combinationally from the state register; all other outputs SHALL be registered.

Reset
REQ-022 rst_n=0 at a clk rising edge SHALL force state CMD, index 0, counters 0, holdoff 0, and all outputs 0 except rx_enable=1 following reset release.
REQ-023 Reset mid-LOAD or mid-INFER SHALL discard progress; no buf_we, infer_start or error pulse SHALL be emitted on the reset edge.

Configuration
REQ-024 Macro IMAGE_RX_TIMEOUT_EN: when defined, REQ-016 timeout logic SHALL be present; when undefined, no timeout counter SHALL exist, rx_err SHALL be tied 0, and LOAD SHALL wait indefinitely.

Verification
REQ-025 Reset, send 0xA5 then 113 bytes 0x01..0x71 -> 113 buf_we pulses, addr 0..112 data matching, image_ready=1, blank_image=0.
REQ-026 Send 0xA5 then 113 x 0x00 -> image_ready=1, blank_image=1; then 0x5A -> infer_start 1 cycle, rx_enable=0; infer_done -> LOADED, rx_enable=1.
REQ-027 Hold byte_valid=1 for 3 cycles with one byte -> exactly one byte_taken and at most one buf_we.
REQ-028 0xA5 then 10 bytes then 10000 idle cycles (macro defined) -> rx_err 1 cycle, state CMD, image_ready=0; undefined -> stays LOAD.
REQ-029 In CMD send 0x5A and 0x33 -> two cmd_err pulses, no infer_start; in LOADED send 0xFF -> image_ready=0, busy=0.
REQ-030 Assert rst_n=0 at byte 50 of a load -> next cycle state CMD, index 0, no buf_we; new 0xA5 load writes from addr 0.
